cjump_rs: RTL and testbench

// Reservation station directly upstream of the conditional-jump FU. Holds up to DEPTH issued cjump ops
// and snoops the CDB to capture their two source values. Dispatches the oldest op with both operands

---
 rtl/cjump_rs_pkg.sv | 28 ++
 rtl/cjump_rs_if.sv | 46 ++++
 rtl/cjump_rs_entry.sv | 51 +++++
 rtl/cjump_rs.sv | 115 +++++++++++
 tb/tb_cjump_rs.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cjump_rs_pkg.sv
// Shared types for the conditional-jump reservation station: widths, entry record, CDB match helper.
// Pure declarations; no timing or flow control lives here.
package cjump_rs_pkg;

    localparam int ROBID_W = 4;
    localparam int DATA_W  = 8;

    typedef logic [ROBID_W-1:0] robid_t;
    typedef logic [DATA_W-1:0]  data_t;

    // Source index 1 is operand a, index 0 is operand b.
    typedef struct packed {
        logic             valid;
        data_t            operand;
        logic [1:0]       rdy;
        robid_t [1:0]     tag;
        data_t  [1:0]     val;
        data_t            wbs;
        data_t            flags;
        robid_t           robid;
    } rs_entry_t;

    function automatic logic cdb_hit(input logic rdy, input robid_t tag,
                                     input logic cdb_vld, input robid_t cdb_id);
        return !rdy && cdb_vld && (tag == cdb_id);
    endfunction

endpackage

// File: rtl/cjump_rs_if.sv
// Issue, CDB snoop and FU dispatch bundle of the cjump reservation station.
// Dispatch side is a registered strobe gated by fu_busy; issue side is valid/ready.
interface cjump_rs_if;
    import cjump_rs_pkg::*;

    logic           issue_valid;
    logic           issue_ready;
    data_t          issue_operand;
    logic [1:0]     issue_rdy;
    robid_t [1:0]   issue_tag;
    data_t  [1:0]   issue_val;
    data_t          issue_wbs;
    data_t          issue_flags;
    robid_t         issue_robid;

    logic           cdb_valid;
    robid_t         cdb_id;
    data_t          cdb_val;

    logic           flush;
    logic           fu_busy;

    logic           fu_transmit;
    data_t          fu_operand;
    data_t          fu_wbs;
    data_t          fu_flags;
    data_t  [1:0]   fu_depvals;
    robid_t         fu_robid;

    modport master (
        output issue_valid, issue_operand, issue_rdy, issue_tag, issue_val,
               issue_wbs, issue_flags, issue_robid,
               cdb_valid, cdb_id, cdb_val, flush, fu_busy,
        input  issue_ready, fu_transmit, fu_operand, fu_wbs, fu_flags,
               fu_depvals, fu_robid
    );

    modport slave (
        input  issue_valid, issue_operand, issue_rdy, issue_tag, issue_val,
               issue_wbs, issue_flags, issue_robid,
               cdb_valid, cdb_id, cdb_val, flush, fu_busy,
        output issue_ready, fu_transmit, fu_operand, fu_wbs, fu_flags,
               fu_depvals, fu_robid
    );

endinterface

// File: rtl/cjump_rs_entry.sv
// One reservation-station slot: load / shift-in / hold, then CDB wakeup on the chosen next value.
// Single-cycle update; no flow control of its own, the top decides load and shift.
module cjump_rs_entry
    import cjump_rs_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush_i,
    input  logic      load_i,
    input  rs_entry_t load_dat_i,
    input  logic      shift_i,
    input  rs_entry_t shift_dat_i,
    input  logic      cdb_valid_i,
    input  robid_t    cdb_id_i,
    input  data_t     cdb_val_i,
    output rs_entry_t entry_o
);

    rs_entry_t entry_q, entry_d, base;

    // Wakeup is applied after selecting the source so shifted and newly issued ops both snoop.
    always_comb begin
        base = entry_q;
        if (load_i) begin
            base = load_dat_i;
        end else if (shift_i) begin
            base = shift_dat_i;
        end
        entry_d = base;
        for (int s = 0; s < 2; s++) begin
            if (base.valid && cdb_hit(base.rdy[s], base.tag[s], cdb_valid_i, cdb_id_i)) begin
                entry_d.rdy[s] = 1'b1;
                entry_d.val[s] = cdb_val_i;
            end
        end
        if (flush_i) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/cjump_rs.sv
// Collapsing reservation station for the cjump FU: oldest operand-ready op dispatched as a one-cycle strobe.
// Issue to strobe is 2 cycles; no dispatch while fu_busy or the previous strobe is out.
module cjump_rs
    import cjump_rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cjump_rs_if.slave    bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    cnt_t      count_q, count_d, count_rem;
    rs_entry_t ent [DEPTH];
    rs_entry_t new_ent;
    logic      sel_vld;
    idx_t      sel_idx;
    logic      dispatch;
    logic      accept;

    logic         fu_transmit_q;
    data_t        fu_operand_q, fu_wbs_q, fu_flags_q;
    data_t [1:0]  fu_depvals_q;
    robid_t       fu_robid_q;

    assign bus.issue_ready = (count_q < cnt_t'(DEPTH));
    assign accept          = bus.issue_valid && bus.issue_ready && !bus.flush;

    // Oldest-first: scanning downward leaves the lowest ready index selected.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && (&ent[i].rdy)) begin
                sel_vld = 1'b1;
                sel_idx = idx_t'(i);
            end
        end
    end

    assign dispatch  = sel_vld && !bus.fu_busy && !fu_transmit_q && !bus.flush;
    assign count_rem = count_q - cnt_t'(dispatch);
    assign count_d   = bus.flush ? '0 : (count_rem + cnt_t'(accept));

    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.operand = bus.issue_operand;
        new_ent.rdy     = bus.issue_rdy;
        new_ent.tag     = bus.issue_tag;
        new_ent.val     = bus.issue_val;
        new_ent.wbs     = bus.issue_wbs;
        new_ent.flags   = bus.issue_flags;
        new_ent.robid   = bus.issue_robid;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_entry_t shift_src;
        if (g == DEPTH - 1) begin : g_top
            assign shift_src = '0;
        end else begin : g_mid
            assign shift_src = ent[g+1];
        end

        cjump_rs_entry u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (bus.flush),
            .load_i      (accept && (count_rem == cnt_t'(g))),
            .load_dat_i  (new_ent),
            .shift_i     (dispatch && (idx_t'(g) >= sel_idx)),
            .shift_dat_i (shift_src),
            .cdb_valid_i (bus.cdb_valid),
            .cdb_id_i    (bus.cdb_id),
            .cdb_val_i   (bus.cdb_val),
            .entry_o     (ent[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            fu_transmit_q <= 1'b0;
            fu_operand_q  <= '0;
            fu_wbs_q      <= '0;
            fu_flags_q    <= '0;
            fu_depvals_q  <= '0;
            fu_robid_q    <= '0;
        end else begin
            count_q       <= count_d;
            fu_transmit_q <= dispatch;
            if (dispatch) begin
                fu_operand_q <= ent[sel_idx].operand;
                fu_wbs_q     <= ent[sel_idx].wbs;
                fu_flags_q   <= ent[sel_idx].flags;
                fu_depvals_q <= ent[sel_idx].val;
                fu_robid_q   <= ent[sel_idx].robid;
            end
        end
    end

    assign bus.fu_transmit = fu_transmit_q;
    assign bus.fu_operand  = fu_operand_q;
    assign bus.fu_wbs      = fu_wbs_q;
    assign bus.fu_flags    = fu_flags_q;
    assign bus.fu_depvals  = fu_depvals_q;
    assign bus.fu_robid    = fu_robid_q;

endmodule

// File: tb/tb_cjump_rs.sv
// Directed bench for cjump_rs: per-cycle vector table plus hand-written backpressure, flush and reset sequences.
module tb_cjump_rs;
    import cjump_rs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cjump_rs_if bus();

    cjump_rs #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   viol     = 0;
    logic prev_tx  = 1'b0;

    typedef struct {
        logic        iv;
        logic [7:0]  op;
        logic [1:0]  rdy;
        logic [3:0]  t1, t0;
        logic [7:0]  v1, v0, wbs, flg;
        logic [3:0]  rob;
        logic        cv;
        logic [3:0]  cid;
        logic [7:0]  cval;
        logic        busy;
        logic        etx;
        logic        erdy;
        logic [15:0] edep;
        logic [3:0]  erob;
        logic [23:0] epay;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int iv, op, rdy, t1, t0, v1, v0, wbs, flg, rob,
                                input int cv, cid, cval, busy,
                                input int etx, erdy, edep, erob, epay);
        vec_t t;
        t.iv = 1'(iv);  t.op = 8'(op);  t.rdy = 2'(rdy);
        t.t1 = 4'(t1);  t.t0 = 4'(t0);  t.v1 = 8'(v1);  t.v0 = 8'(v0);
        t.wbs = 8'(wbs); t.flg = 8'(flg); t.rob = 4'(rob);
        t.cv = 1'(cv);  t.cid = 4'(cid); t.cval = 8'(cval); t.busy = 1'(busy);
        t.etx = 1'(etx); t.erdy = 1'(erdy); t.edep = 16'(edep);
        t.erob = 4'(erob); t.epay = 24'(epay);
        return t;
    endfunction

    function automatic vec_t ex(input int etx, erdy, edep, erob, epay);
        return mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, etx,erdy,edep,erob,epay);
    endfunction

    function automatic logic [31:0] pay();
        return 32'({bus.fu_operand, bus.fu_wbs, bus.fu_flags});
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_operand = '0;
        bus.issue_rdy     = '0;
        bus.issue_tag     = '0;
        bus.issue_val     = '0;
        bus.issue_wbs     = '0;
        bus.issue_flags   = '0;
        bus.issue_robid   = '0;
        bus.cdb_valid     = 1'b0;
        bus.cdb_id        = '0;
        bus.cdb_val       = '0;
        bus.flush         = 1'b0;
        bus.fu_busy       = 1'b0;
    endtask

    task automatic issue(input int op, rdy, v1, v0, rob);
        bus.issue_valid   = 1'b1;
        bus.issue_operand = 8'(op);
        bus.issue_rdy     = 2'(rdy);
        bus.issue_tag     = '0;
        bus.issue_val     = {8'(v1), 8'(v0)};
        bus.issue_wbs     = 8'(op + 1);
        bus.issue_flags   = 8'(op + 2);
        bus.issue_robid   = 4'(rob);
    endtask

    task automatic drive(input vec_t v);
        bus.issue_valid   = v.iv;
        bus.issue_operand = v.op;
        bus.issue_rdy     = v.rdy;
        bus.issue_tag     = {v.t1, v.t0};
        bus.issue_val     = {v.v1, v.v0};
        bus.issue_wbs     = v.wbs;
        bus.issue_flags   = v.flg;
        bus.issue_robid   = v.rob;
        bus.cdb_valid     = v.cv;
        bus.cdb_id        = v.cid;
        bus.cdb_val       = v.cval;
        bus.flush         = 1'b0;
        bus.fu_busy       = v.busy;
    endtask

    always @(negedge clk) begin
        if (bus.fu_transmit && prev_tx) viol++;
        prev_tx = bus.fu_transmit;
    end

    initial begin
        // Ready path
        tbl.push_back(mk(1,'h0A,3,0,0,'h80,'h42,'h55,'h3C,3, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h8042,3,'h0A553C));
        tbl.push_back(ex(0,1,0,0,0));
        // Wakeup of operand a: wrong tag first, then the right one
        tbl.push_back(mk(1,'h01,1,5,0,0,'h22,'h10,'h20,6, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,6,'h99,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,5,'h7F,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h7F22,6,'h011020));
        tbl.push_back(ex(0,1,0,0,0));
        // Capture in the issue cycle
        tbl.push_back(mk(1,'h02,2,0,2,'h33,0,'h30,'h40,7, 1,2,'h11,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h3311,7,'h023040));
        // Matching broadcast on already-ready sources is ignored
        tbl.push_back(mk(1,'h03,3,9,9,'h44,'h55,'h50,'h60,8, 1,9,'hEE,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h4455,8,'h035060));
        // One broadcast wakes both sources
        tbl.push_back(mk(1,'h04,0,4,4,0,0,'h70,'h80,9, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,4,'h5A,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h5A5A,9,'h047080));
        // Fill under busy, 5th dropped, age-ordered drain, waiting op last
        tbl.push_back(mk(1,'hF1,1,'hC,0,0,'h01,'hB1,'hC1,1, 0,0,0,1, 0,1,0,0,0));
        tbl.push_back(mk(1,'hF2,3,0,0,'h02,'h02,'hB2,'hC2,2, 0,0,0,1, 0,1,0,0,0));
        tbl.push_back(mk(1,'hF3,3,0,0,'h03,'h03,'hB3,'hC3,3, 0,0,0,1, 0,1,0,0,0));
        tbl.push_back(mk(1,'hF4,3,0,0,'h04,'h04,'hB4,'hC4,4, 0,0,0,1, 0,1,0,0,0));
        tbl.push_back(mk(1,'hF5,3,0,0,'h05,'h05,'hB5,'hC5,5, 0,0,0,1, 0,0,0,0,0));
        tbl.push_back(ex(0,0,0,0,0));
        tbl.push_back(ex(1,1,'h0202,2,'hF2B2C2));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h0303,3,'hF3B3C3));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h0404,4,'hF4B4C4));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,'hC,'h77,0, 0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(1,1,'h7701,1,'hF1B1C1));
        tbl.push_back(ex(0,1,0,0,0));
        tbl.push_back(ex(0,1,0,0,0));

        idle();
        rst_n = 1'b0;
        #12;
        check("rst_tx", 0, 32'(bus.fu_transmit), 0);
        check("rst_ready", 0, 32'(bus.issue_ready), 1);
        check("rst_dep", 0, 32'(bus.fu_depvals), 0);
        check("rst_rob", 0, 32'(bus.fu_robid), 0);
        check("rst_pay", 0, pay(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            check("tx", k, 32'(bus.fu_transmit), 32'(tbl[k].etx));
            check("ready", k, 32'(bus.issue_ready), 32'(tbl[k].erdy));
            if (tbl[k].etx) begin
                check("dep", k, 32'(bus.fu_depvals), 32'(tbl[k].edep));
                check("rob", k, 32'(bus.fu_robid), 32'(tbl[k].erob));
                check("pay", k, pay(), 32'(tbl[k].epay));
            end
            tick();
        end

        // Backpressure: two ready ops held off by fu_busy, then released
        idle(); issue('h20, 3, 'hA1, 'hA2, 'hA); bus.fu_busy = 1'b1;
        check("bp_tx", 0, 32'(bus.fu_transmit), 0); tick();
        idle(); issue('h30, 3, 'hB1, 'hB2, 'hB); bus.fu_busy = 1'b1;
        check("bp_tx", 1, 32'(bus.fu_transmit), 0); tick();
        idle(); bus.fu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold", i, 32'(bus.fu_transmit), 0); tick();
        end
        bus.fu_busy = 1'b0;
        check("bp_rel", 0, 32'(bus.fu_transmit), 0); tick();
        check("bp_rel", 1, 32'(bus.fu_transmit), 1);
        check("bp_rob", 1, 32'(bus.fu_robid), 'hA);
        check("bp_dep", 1, 32'(bus.fu_depvals), 'hA1A2); tick();
        check("bp_rel", 2, 32'(bus.fu_transmit), 0); tick();
        check("bp_rel", 3, 32'(bus.fu_transmit), 1);
        check("bp_rob", 3, 32'(bus.fu_robid), 'hB); tick();
        check("bp_rel", 4, 32'(bus.fu_transmit), 0);

        // Flush with three held entries and a concurrent issue
        for (int r = 0; r < 3; r++) begin
            idle(); issue('h40 + r, 3, r, r, r + 1); bus.fu_busy = 1'b1;
            check("fl_fill_ready", r, 32'(bus.issue_ready), 1); tick();
        end
        idle(); issue('h50, 3, 'hE1, 'hE2, 'hE); bus.flush = 1'b1;
        check("fl_tx", 0, 32'(bus.fu_transmit), 0); tick();
        idle();
        for (int i = 1; i < 4; i++) begin
            check("fl_tx", i, 32'(bus.fu_transmit), 0);
            check("fl_ready", i, 32'(bus.issue_ready), 1); tick();
        end
        for (int r = 0; r < 4; r++) begin
            idle(); issue('h60 + r, 3, r, r, r); bus.fu_busy = 1'b1;
            check("fl_refill_ready", r, 32'(bus.issue_ready), 1); tick();
        end
        idle(); bus.fu_busy = 1'b1;
        check("fl_full", 0, 32'(bus.issue_ready), 0);
        bus.flush = 1'b1; tick();
        idle();
        check("fl_empty", 0, 32'(bus.issue_ready), 1);

        // Asynchronous reset while a strobe is out
        issue('h05, 3, 'hD1, 'hD2, 'hD); tick();
        idle(); tick();
        check("ar_tx_before", 0, 32'(bus.fu_transmit), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_tx", 0, 32'(bus.fu_transmit), 0);
        check("ar_dep", 0, 32'(bus.fu_depvals), 0);
        check("ar_rob", 0, 32'(bus.fu_robid), 0);
        check("ar_pay", 0, pay(), 0);
        check("ar_ready", 0, 32'(bus.issue_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_tx_after", 0, 32'(bus.fu_transmit), 0);
        tick();
        check("ar_tx_after", 1, 32'(bus.fu_transmit), 0);

        check("no_back_to_back", 0, 32'(viol), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
